// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1011 detector: one shifter plus a one-word
// holding register so consecutive words stream with no idle bit between them.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             bit_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [CW-1:0]    r_cnt;
  logic             r_bit_out;
  logic             r_word_ready;
  logic             r_busy;

  logic             w_accept;
  logic             w_consume;
  logic             w_last;
  logic             w_to_hold;
  logic [WIDTH-1:0] w_shifted;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_hold_full_nxt;
  logic             w_bit_nxt;

  assign w_accept  = word_valid && r_word_ready;
  assign w_consume = (r_state == S_SHIFT) && bit_en;
  assign w_last    = w_consume && (r_cnt == LAST_CNT);
  assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_hold_full_nxt = r_hold_full;
    w_to_hold       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = word_in;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          // Word boundary: pick the next word from hold, then the input, else drain.
          if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
          end else if (w_accept) begin
            w_shift_nxt = word_in;
          end else begin
            w_state_nxt = S_IDLE;
            w_shift_nxt = '0;
          end
        end else begin
          if (w_consume) w_shift_nxt = w_shifted;
          if (w_accept) begin
            w_to_hold       = 1'b1;
            w_hold_full_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_shift_nxt = '0;
      end
    endcase
    w_bit_nxt = 1'b0;
    if (w_state_nxt == S_SHIFT)
      w_bit_nxt = MSB_FIRST ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_cnt        <= '0;
      r_bit_out    <= 1'b0;
      r_word_ready <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_hold_full <= w_hold_full_nxt;
      if (w_to_hold) r_hold <= word_in;
      if (w_consume) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      r_bit_out    <= w_bit_nxt;
      r_word_ready <= !w_hold_full_nxt;
      r_busy       <= (w_state_nxt == S_SHIFT) || w_hold_full_nxt;
    end
  end

  assign word_ready = r_word_ready;
  assign bit_out    = r_bit_out;
  assign bit_valid  = (r_state == S_SHIFT);
  assign busy       = r_busy;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first and LSB-first instances share stimulus.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] word_in;
  logic       word_valid;
  logic       bit_en;

  logic m_ready, m_bit, m_vld, m_busy;
  logic l_ready, l_bit, l_vld, l_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(m_ready), .bit_en(bit_en), .bit_out(m_bit), .bit_valid(m_vld), .busy(m_busy)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(l_ready), .bit_en(bit_en), .bit_out(l_bit), .bit_valid(l_vld), .busy(l_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; word_valid = 1'b1; word_in = 8'hFF; bit_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({m_vld, m_bit, m_ready, m_busy} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got vld/bit/rdy/busy=%b want 0000", i, {m_vld, m_bit, m_ready, m_busy});
      end
    end
    reset = 1'b0;
    tick();
    total++;
    if (m_ready !== 1'b1 || m_vld !== 1'b0 || m_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b vld=%b busy=%b want rdy=1 vld=0 busy=0", m_ready, m_vld, m_busy);
    end
    word_valid = 1'b0;
    tick();
    total++;
    if (m_vld !== 1'b0 || m_bit !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_accept got vld=%b bit=%b want 0 0", m_vld, m_bit);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp;
    logic [3:0] hist;
    int         seen;
    exp = 8'hB0; hist = 4'b0; seen = 0;
    word_in = 8'hB0; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (m_vld !== 1'b1 || m_bit !== exp[7-i]) begin
        bad++;
        $display("FAIL single_bit idx=%0d got vld=%b bit=%b want vld=1 bit=%b", i, m_vld, m_bit, exp[7-i]);
      end
      hist = {hist[2:0], m_bit};
      if (hist == 4'b1011) seen++;
      tick();
    end
    total++;
    if (m_vld !== 1'b0 || m_bit !== 1'b0 || m_busy !== 1'b0) begin
      bad++;
      $display("FAIL single_end got vld=%b bit=%b busy=%b want 0 0 0", m_vld, m_bit, m_busy);
    end
    total++;
    if (seen !== 1) begin
      bad++;
      $display("FAIL single_detect got matches=%0d want 1", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    exp = 16'hB00B;
    word_in = 8'hB0; word_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      total++;
      if (m_vld !== 1'b1 || m_bit !== exp[15-i]) begin
        bad++;
        $display("FAIL b2b_bit idx=%0d got vld=%b bit=%b want vld=1 bit=%b", i, m_vld, m_bit, exp[15-i]);
      end
      if (i == 0) word_in = 8'h0B;
      if (i == 1) word_valid = 1'b0;
      if (i >= 1 && i <= 7) begin
        total++;
        if (m_ready !== 1'b0 || m_busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b_hold_full idx=%0d got rdy=%b busy=%b want rdy=0 busy=1", i, m_ready, m_busy);
        end
      end
      if (i == 8) begin
        total++;
        if (m_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready_back got rdy=%b want 1", m_ready);
        end
      end
      tick();
    end
    total++;
    if (m_vld !== 1'b0 || m_bit !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got vld=%b bit=%b want 0 0", m_vld, m_bit);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp;
    exp = 8'hB0;
    word_in = 8'hB0; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    tick();
    bit_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (m_vld !== 1'b1 || m_bit !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got vld=%b bit=%b want vld=1 bit=0", i, m_vld, m_bit);
      end
    end
    bit_en = 1'b1;
    for (int i = 2; i < 8; i++) begin
      tick();
      total++;
      if (m_vld !== 1'b1 || m_bit !== exp[7-i]) begin
        bad++;
        $display("FAIL stall_resume idx=%0d got vld=%b bit=%b want vld=1 bit=%b", i, m_vld, m_bit, exp[7-i]);
      end
    end
    tick();
    total++;
    if (m_vld !== 1'b0) begin
      bad++;
      $display("FAIL stall_end got vld=%b want 0", m_vld);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp;
    exp = 8'b1011_0000;
    word_in = 8'h0D; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (l_vld !== 1'b1 || l_bit !== exp[7-i]) begin
        bad++;
        $display("FAIL lsb_bit idx=%0d got vld=%b bit=%b want vld=1 bit=%b", i, l_vld, l_bit, exp[7-i]);
      end
      tick();
    end
    total++;
    if (l_vld !== 1'b0 || l_busy !== 1'b0) begin
      bad++;
      $display("FAIL lsb_end got vld=%b busy=%b want 0 0", l_vld, l_busy);
    end
  endtask

  task automatic test_reset_mid();
    word_in = 8'hB0; word_valid = 1'b1;
    tick();
    word_in = 8'h0B;
    tick();
    word_valid = 1'b0;
    tick();
    total++;
    if (m_bit !== 1'b1 || m_ready !== 1'b0 || m_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got bit=%b rdy=%b busy=%b want 1 0 1", m_bit, m_ready, m_busy);
    end
    reset = 1'b1;
    tick();
    total++;
    if (m_vld !== 1'b0 || m_busy !== 1'b0 || m_bit !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got vld=%b busy=%b bit=%b want 0 0 0", m_vld, m_busy, m_bit);
    end
    reset = 1'b0;
    tick();
    total++;
    if (m_ready !== 1'b1 || m_vld !== 1'b0) begin
      bad++;
      $display("FAIL mid_release got rdy=%b vld=%b want 1 0", m_ready, m_vld);
    end
    word_in = 8'hFF; word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (m_vld !== 1'b1 || m_bit !== 1'b1) begin
        bad++;
        $display("FAIL mid_new_bit idx=%0d got vld=%b bit=%b want 1 1", i, m_vld, m_bit);
      end
      tick();
    end
    total++;
    if (m_vld !== 1'b0 || m_busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_new_end got vld=%b busy=%b want 0 0", m_vld, m_busy);
    end
  endtask

  initial begin
    reset = 1'b1; word_in = 8'h00; word_valid = 1'b0; bit_en = 1'b1;
    test_reset();
    test_single();
    tick();
    test_back_to_back();
    tick();
    test_stall();
    tick();
    test_lsb_first();
    tick();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
